// File: rtl/vga_pkg.sv
// Definitions shared by the camera writer and the VGA display path: colours,
// default geometry, RGB565 field positions and capture FSM states.
package vga_pkg;

    typedef logic [2:0] rgb3_t;

    localparam rgb3_t BLACK = 3'b000;
    localparam rgb3_t RED   = 3'b100;
    localparam rgb3_t WHITE = 3'b111;

    localparam int H_PIX_DEF = 640;
    localparam int V_PIX_DEF = 480;

    // MSB of each RGB565 field within its camera byte
    localparam int PH0_R_MSB = 7;
    localparam int PH0_G_MSB = 2;
    localparam int PH1_B_MSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ACTIVE
    } cap_state_t;

    // 8 equal vertical bars 000..111 across a line of 'width' output pixels
    function automatic rgb3_t bar_colour(input int x_out, input int width);
        return 3'((x_out * 8) / width);
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera byte stream in, frame-buffer write port out.
interface cam_capture_if #(
    parameter int ADDR_W = 15
);
    logic              cam_vsync;
    logic              cam_href;
    logic              cam_valid;
    logic [7:0]        cam_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;

    modport master (
        output cam_vsync, cam_href, cam_valid, cam_data,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  cam_vsync, cam_href, cam_valid, cam_data,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/cam_byte_pack.sv
// Pairs camera bytes into RGB565 pixels and thresholds them to 3-bit RGB.
module cam_byte_pack
    import vga_pkg::*;
(
    input  logic       clk_25,
    input  logic       reset,
    input  logic       clr,
    input  logic       byte_en,
    input  logic [7:0] data,
    output logic       phase,
    output logic       pix_valid,
    output rgb3_t      pix_rgb
);
    logic [7:0] hi_byte;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            phase   <= 1'b0;
            hi_byte <= '0;
        end else if (clr) begin
            phase   <= 1'b0;
        end else if (byte_en) begin
            if (!phase) hi_byte <= data;
            phase <= ~phase;
        end
    end

    // Pixel is complete on the phase-1 byte; the top registers it
    assign pix_valid = byte_en & phase;
    assign pix_rgb   = {hi_byte[PH0_R_MSB], hi_byte[PH0_G_MSB], data[PH1_B_MSB]};

endmodule

// File: rtl/cam_capture.sv
// Camera-side frame-buffer writer: FSM, x/y counters, decimation, addressing.
// Define CAM_TESTPAT_EN to replace camera pixels with vertical colour bars.
module cam_capture
    import vga_pkg::*;
#(
    parameter int H_PIX  = H_PIX_DEF,
    parameter int V_PIX  = V_PIX_DEF,
    parameter int DECIM  = 4,
    parameter int ADDR_W = 15
) (
    input  logic          clk_25,
    input  logic          reset,
    input  logic          capture_en,
    cam_capture_if.slave  cam,
    output logic          frame_done,
    output logic          frame_err
);
    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_PIX + 1);
    localparam int XO = H_PIX / DECIM;

    cap_state_t        state;
    logic              vsync_d, href_d, line_had_byte;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr_cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    rgb3_t             wr_data_q;

    logic  vs_rise, vs_fall, line_end, active, byte_en, clr;
    logic  phase, pix_valid, in_frame, on_grid;
    rgb3_t pix_rgb, pix_colour;

    assign vs_rise  = cam.cam_vsync & ~vsync_d;
    assign vs_fall  = ~cam.cam_vsync & vsync_d;
    assign active   = (state == ST_ACTIVE);
    assign line_end = active & href_d & ~cam.cam_href;
    // vsync rise takes priority over a pixel completing in the same cycle
    assign byte_en  = active & ~vs_rise & cam.cam_href & cam.cam_valid;
    assign clr      = ~active | vs_rise | line_end;

    assign in_frame = (x < XW'(H_PIX)) && (y < YW'(V_PIX));
    assign on_grid  = ((x & XW'(DECIM - 1)) == '0) && ((y & YW'(DECIM - 1)) == '0);

`ifdef CAM_TESTPAT_EN
    assign pix_colour = bar_colour(int'(x) / DECIM, XO);
`else
    assign pix_colour = pix_rgb;
`endif

    cam_byte_pack u_pack (
        .clk_25    (clk_25),
        .reset     (reset),
        .clr       (clr),
        .byte_en   (byte_en),
        .data      (cam.cam_data),
        .phase     (phase),
        .pix_valid (pix_valid),
        .pix_rgb   (pix_rgb)
    );

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state         <= ST_IDLE;
            vsync_d       <= 1'b0;
            href_d        <= 1'b0;
            line_had_byte <= 1'b0;
            x             <= '0;
            y             <= '0;
            addr_cnt      <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= BLACK;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            vsync_d    <= cam.cam_vsync;
            href_d     <= cam.cam_href;
            wr_en_q    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: if (cam.cam_vsync) state <= ST_SYNC;
                ST_SYNC: begin
                    if (vs_fall && capture_en) begin
                        state         <= ST_ACTIVE;
                        x             <= '0;
                        y             <= '0;
                        line_had_byte <= 1'b0;
                        addr_cnt      <= '0;
                        wr_addr_q     <= '0;
                        frame_err     <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        state      <= ST_SYNC;
                    end else begin
                        if (byte_en) line_had_byte <= 1'b1;
                        if (pix_valid) begin
                            if (in_frame) begin
                                if (on_grid) begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= addr_cnt;
                                    wr_data_q <= pix_colour;
                                    addr_cnt  <= addr_cnt + 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                            if (x < XW'(H_PIX)) x <= x + 1'b1;
                        end
                        // line end cannot coincide with a byte: href is low
                        if (line_end) begin
                            x             <= '0;
                            line_had_byte <= 1'b0;
                            if (line_had_byte && (y < YW'(V_PIX))) y <= y + 1'b1;
                            if (phase) frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cam.wr_en   = wr_en_q;
    assign cam.wr_addr = wr_addr_q;
    assign cam.wr_data = wr_data_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture with a small 8x4 camera, decimation 2.
module tb_cam_capture;
    localparam int H = 8, V = 4, D = 2, AW = 3;

    logic clk_25 = 1'b0;
    logic reset, capture_en;
    logic frame_done, frame_err;
    int   errs = 0, checks = 0, done_cnt = 0;
    int   log_addr[$];
    int   log_data[$];

    always #5 clk_25 = ~clk_25;

    cam_capture_if #(.ADDR_W(AW)) bus ();

    cam_capture #(.H_PIX(H), .V_PIX(V), .DECIM(D), .ADDR_W(AW)) dut (
        .clk_25     (clk_25),
        .reset      (reset),
        .capture_en (capture_en),
        .cam        (bus),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always @(negedge clk_25) begin
        if (bus.wr_en) begin
            log_addr.push_back(int'(bus.wr_addr));
            log_data.push_back(int'(bus.wr_data));
        end
        if (frame_done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk_25);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: red pixels; mode 1: green on even pixels, blue on odd
    function automatic logic [7:0] byte_of(input int i, input int mode);
        int p = i / 2;
        if (mode == 0) return (i % 2 == 0) ? 8'hF8 : 8'h00;
        if (p % 2 == 0) return (i % 2 == 0) ? 8'h07 : 8'hE0;
        return (i % 2 == 0) ? 8'h00 : 8'h1F;
    endfunction

    // Expected colour of the write landing at buffer address a
    function automatic int exp_data(input int a, input int mode);
`ifdef CAM_TESTPAT_EN
        return ((a % (H / D)) * 8) / (H / D);
`else
        return (mode == 0) ? 3'b100 : 3'b010;
`endif
    endfunction

    // Bytes first..first+n-1; after each phase-1 byte a write is due one cycle later
    task automatic send_bytes(input int first, input int n, input int mode, input bit row_wr);
        for (int i = first; i < first + n; i++) begin
            int p = i / 2;
            bus.cam_data  = byte_of(i, mode);
            bus.cam_valid = 1'b1;
            tick();
            if (i % 2 == 1) check("wr_latency", int'(bus.wr_en), int'(row_wr && (p % 2 == 0) && p < H));
            bus.cam_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_line(input int n, input int mode, input bit row_wr);
        bus.cam_href = 1'b1;
        tick();
        send_bytes(0, n, mode, row_wr);
        bus.cam_href = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(input bit wr);
        for (int l = 0; l < V; l++) send_line(2 * H, 0, wr && (l % 2 == 0));
    endtask

    task automatic vs_rise(input int exp_done);
        bus.cam_vsync = 1'b1;
        tick();
        check("frame_done_pulse", int'(frame_done), exp_done);
        tick();
        check("frame_done_clear", int'(frame_done), 0);
        tick();
    endtask

    task automatic vs_fall;
        bus.cam_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_log(input int n, input int mode);
        check("write_count", log_addr.size(), n);
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            check("write_addr", log_addr[i], i);
            check("write_data", log_data[i], exp_data(i, mode));
        end
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        int d0;
        reset = 1'b1; capture_en = 1'b1;
        bus.cam_vsync = 1'b1; bus.cam_href = 1'b0; bus.cam_valid = 1'b0; bus.cam_data = 8'h00;
        tick(); tick();
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_data", int'(bus.wr_data), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        tick(); tick();

        // Full red frame
        vs_fall();
        send_frame(1'b1);
        check("red_err", int'(frame_err), 0);
        vs_rise(1);
        check_log(8, 0);

        // Green/blue line, then a 15-byte line
        vs_fall();
        send_line(2 * H, 1, 1'b1);
        check_log(4, 1);
        check("err_before_short", int'(frame_err), 0);
        send_line(2 * H - 1, 0, 1'b0);
        check("err_short_line", int'(frame_err), 1);
        vs_rise(1);
        check("err_sticky", int'(frame_err), 1);
        vs_fall();
        check("err_cleared", int'(frame_err), 0);
        vs_rise(1);

        // Capture disabled at vsync fall: whole frame skipped
        capture_en = 1'b0;
        d0 = done_cnt;
        vs_fall();
        capture_en = 1'b1;
        send_frame(1'b0);
        vs_rise(0);
        check("dis_done_cnt", done_cnt - d0, 0);
        check_log(0, 0);

        // Capture resumes on the following frame
        vs_fall();
        send_frame(1'b1);
        vs_rise(1);
        check_log(8, 0);

        // Reset mid-line after 3 writes
        vs_fall();
        bus.cam_href = 1'b1;
        tick();
        send_bytes(0, 10, 0, 1'b1);
        check("pre_rst_addr", int'(bus.wr_addr), 2);
        reset = 1'b1;
        tick();
        check("mid_rst_wr_en", int'(bus.wr_en), 0);
        check("mid_rst_wr_addr", int'(bus.wr_addr), 0);
        check("mid_rst_wr_data", int'(bus.wr_data), 0);
        check("mid_rst_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        send_bytes(10, 2 * H - 10, 0, 1'b0);
        bus.cam_href = 1'b0;
        tick(); tick();
        for (int l = 1; l < V; l++) send_line(2 * H, 0, 1'b0);
        d0 = done_cnt;
        vs_rise(0);
        check("rst_frame_done_cnt", done_cnt - d0, 0);
        check_log(3, 0);

        // Next full frame starts again at address 0
        vs_fall();
        send_frame(1'b1);
        vs_rise(1);
        check_log(8, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
